irq_ctrl_multi: RTL and testbench



---
 rtl/irq_ctrl_multi.sv | 141 ++++++++++++++
 tb/tb_irq_ctrl_multi.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl_multi.sv
// Parametrised interrupt controller for the V30: per-channel edge/level mode,
// masking, fixed priority (channel 0 highest) and optional in-service nesting.
module irq_ctrl_multi #(
  parameter int         NUM_IRQ    = 8,
  parameter logic [8:0] VEC_BASE   = 9'h080,
  parameter int         VEC_STRIDE = 8,
  parameter logic [7:0] RESET_MASK = 8'h00,
  parameter logic [7:0] RESET_MODE = 8'hFF,
  parameter bit         AUTO_EOI   = 1'b1
) (
  input  logic               CLK_32M,
  input  logic               reset_n,
  input  logic               ce,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_rq,
  output logic [8:0]         irq_vector,
  input  logic               irq_ack,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [7:0]         cfg_din,
  output logic [7:0]         cfg_dout
);
  // state | meaning
  // IDLE  | no request outstanding; grant the winner on the next ce
  // REQ   | irq_rq high, vector frozen until ack on ce
  typedef enum logic {IDLE, REQ} state_t;
  state_t state, state_n;

  logic [NUM_IRQ-1:0] mask, mode, pend_lat, prev, isr;
  logic [NUM_IRQ-1:0] edge_set, pend_nxt, pend_view, elig, gclr, lat_n;
  logic [NUM_IRQ-1:0] eoi_clr, isr_set, isr_n;
  logic [8:0]         base, vec_calc;
  logic [2:0]         gnt_idx, win;
  logic               any_elig, grant, ack_fire, isr_acc;
  logic               wr_mask, wr_mode, wr_eoi, wr_base;

  assign wr_mask = cfg_we && (cfg_addr == 2'd0);
  assign wr_mode = cfg_we && (cfg_addr == 2'd1);
  assign wr_eoi  = cfg_we && (cfg_addr == 2'd2);
  assign wr_base = cfg_we && (cfg_addr == 2'd3);

  // pend_nxt includes this ce's edges so an edge can be granted in the same ce
  assign edge_set  = ce ? (irq_in & ~prev & mode) : '0;
  assign pend_nxt  = ((pend_lat | edge_set) & mode) | (irq_in & ~mode);
  assign pend_view = (pend_lat & mode) | (irq_in & ~mode);
  assign irq_rq    = (state == REQ);

  always_comb begin
    elig    = '0;
    win     = '0;
    isr_acc = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      isr_acc = isr_acc | isr[i];
      elig[i] = pend_nxt[i] & ~mask[i] & ~isr_acc;
    end
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) win = 3'(i);
    end
    any_elig = |elig;
  end

  always_comb begin
    state_n  = state;
    grant    = 1'b0;
    ack_fire = 1'b0;
    case (state)
      IDLE: if (ce && any_elig) begin
        grant   = 1'b1;
        state_n = REQ;
      end
      REQ: if (ce && irq_ack) begin
        ack_fire = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign vec_calc = base + 9'(int'(win) * VEC_STRIDE);

  // A granted latch survives only if a fresh edge arrives on top of an older one.
  always_comb begin
    gclr    = '0;
    lat_n   = '0;
    eoi_clr = '0;
    isr_set = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      gclr[i]    = grant && (win == 3'(i));
      lat_n[i]   = gclr[i] ? (pend_lat[i] & edge_set[i]) : (pend_lat[i] | edge_set[i]);
      isr_set[i] = ack_fire && (gnt_idx == 3'(i));
    end
    if (wr_mode) lat_n = lat_n & cfg_din[NUM_IRQ-1:0];
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (isr[i]) begin
        eoi_clr    = '0;
        eoi_clr[i] = 1'b1;
      end
    end
    if (AUTO_EOI) isr_n = '0;
    else          isr_n = (isr & ~(wr_eoi ? eoi_clr : '0)) | isr_set;
  end

  always_comb begin
    cfg_dout = '0;
    case (cfg_addr)
      2'd0:    cfg_dout[NUM_IRQ-1:0] = mask;
      2'd1:    cfg_dout[NUM_IRQ-1:0] = mode;
      2'd2:    cfg_dout[NUM_IRQ-1:0] = pend_view;
      default: cfg_dout[NUM_IRQ-1:0] = isr;
    endcase
  end

  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      mask       <= RESET_MASK[NUM_IRQ-1:0];
      mode       <= RESET_MODE[NUM_IRQ-1:0];
      base       <= VEC_BASE;
      pend_lat   <= '0;
      prev       <= '0;
      isr        <= '0;
      irq_vector <= VEC_BASE;
      gnt_idx    <= '0;
    end else begin
      if (wr_mask) mask <= cfg_din[NUM_IRQ-1:0];
      if (wr_mode) mode <= cfg_din[NUM_IRQ-1:0];
      if (wr_base) base <= {cfg_din, 1'b0};
      if (ce)      prev <= irq_in;
      pend_lat <= lat_n;
      isr      <= isr_n;
      if (grant) begin
        irq_vector <= vec_calc;
        gnt_idx    <= win;
      end
    end
  end
endmodule

// File: tb/tb_irq_ctrl_multi.sv
// Directed bench: instance a uses default params (auto EOI), instance b nests
// with explicit EOI; both share clock, reset and ce.
module tb_irq_ctrl_multi;
  logic       CLK_32M, reset_n, ce;
  logic [7:0] irq_in_a, irq_in_b;
  logic       ack_a, ack_b, we_a, we_b;
  logic [1:0] addr_a, addr_b;
  logic [7:0] din_a, din_b, dout_a, dout_b;
  logic       rq_a, rq_b;
  logic [8:0] vec_a, vec_b;
  int         n_assert = 0;
  int         n_fail   = 0;

  irq_ctrl_multi dut_a (
    .CLK_32M(CLK_32M), .reset_n(reset_n), .ce(ce), .irq_in(irq_in_a),
    .irq_rq(rq_a), .irq_vector(vec_a), .irq_ack(ack_a), .cfg_we(we_a),
    .cfg_addr(addr_a), .cfg_din(din_a), .cfg_dout(dout_a)
  );

  irq_ctrl_multi #(.AUTO_EOI(1'b0)) dut_b (
    .CLK_32M(CLK_32M), .reset_n(reset_n), .ce(ce), .irq_in(irq_in_b),
    .irq_rq(rq_b), .irq_vector(vec_b), .irq_ack(ack_b), .cfg_we(we_b),
    .cfg_addr(addr_b), .cfg_din(din_b), .cfg_dout(dout_b)
  );

  initial CLK_32M = 1'b0;
  always #5 CLK_32M = ~CLK_32M;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_32M);
    #1;
  endtask

  task automatic wr_a(input logic [1:0] a, input logic [7:0] d);
    addr_a = a; din_a = d; we_a = 1'b1;
    tick();
    we_a = 1'b0;
  endtask

  task automatic wr_b(input logic [1:0] a, input logic [7:0] d);
    addr_b = a; din_b = d; we_b = 1'b1;
    tick();
    we_b = 1'b0;
  endtask

  task automatic rd_a(input string tag, input logic [1:0] a, input logic [7:0] exp);
    addr_a = a;
    #1;
    chk(tag, 16'(dout_a), 16'(exp));
  endtask

  task automatic rd_b(input string tag, input logic [1:0] a, input logic [7:0] exp);
    addr_b = a;
    #1;
    chk(tag, 16'(dout_b), 16'(exp));
  endtask

  task automatic ack_pulse_a();
    ack_a = 1'b1;
    tick();
    ack_a = 1'b0;
  endtask

  task automatic ack_pulse_b();
    ack_b = 1'b1;
    tick();
    ack_b = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; ce = 1'b1;
    irq_in_a = '0; irq_in_b = '0; ack_a = 0; ack_b = 0;
    we_a = 0; we_b = 0; addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
    #12;
    chk("rst_rq", 16'(rq_a), 16'h0);
    chk("rst_vec", 16'(vec_a), 16'h080);
    rd_a("rst_mask", 2'd0, 8'h00);
    rd_a("rst_mode", 2'd1, 8'hFF);
    reset_n = 1'b1;
    tick();
    chk("idle_rq", 16'(rq_a), 16'h0);

    // VBLK then HINT
    irq_in_a = 8'h01; tick(); irq_in_a = 8'h00;
    chk("vblk_rq", 16'(rq_a), 16'h1);
    chk("vblk_vec", 16'(vec_a), 16'h080);
    tick();
    chk("vblk_hold", 16'(rq_a), 16'h1);
    ack_pulse_a();
    chk("vblk_ack", 16'(rq_a), 16'h0);
    tick();
    chk("vblk_once", 16'(rq_a), 16'h0);
    irq_in_a = 8'h02; tick(); irq_in_a = 8'h00;
    chk("hint_vec", 16'(vec_a), 16'h088);
    ack_pulse_a();
    chk("hint_ack", 16'(rq_a), 16'h0);

    // simultaneous edges on channels 0 and 1
    irq_in_a = 8'h03; tick(); irq_in_a = 8'h00;
    chk("sim_vec0", 16'(vec_a), 16'h080);
    rd_a("sim_pend", 2'd2, 8'h02);
    ack_pulse_a();
    chk("sim_gap", 16'(rq_a), 16'h0);
    tick();
    chk("sim_rq1", 16'(rq_a), 16'h1);
    chk("sim_vec1", 16'(vec_a), 16'h088);
    ack_pulse_a();
    rd_a("sim_pend0", 2'd2, 8'h00);

    // masking holds a latched edge until unmasked
    wr_a(2'd0, 8'h02);
    irq_in_a = 8'h02; tick(); irq_in_a = 8'h00;
    chk("mask_norq", 16'(rq_a), 16'h0);
    rd_a("mask_pend", 2'd2, 8'h02);
    wr_a(2'd0, 8'h00);
    chk("unmask_edge", 16'(rq_a), 16'h0);
    tick();
    chk("unmask_rq", 16'(rq_a), 16'h1);
    chk("unmask_vec", 16'(vec_a), 16'h088);
    ack_pulse_a();

    // nesting with explicit EOI
    irq_in_b = 8'h04; tick(); irq_in_b = 8'h00;
    chk("n_vec2", 16'(vec_b), 16'h090);
    ack_pulse_b();
    rd_b("n_isr4", 2'd3, 8'h04);
    irq_in_b = 8'h08; tick(); irq_in_b = 8'h00;
    chk("n_block3", 16'(rq_b), 16'h0);
    irq_in_b = 8'h02; tick(); irq_in_b = 8'h00;
    chk("n_rq1", 16'(rq_b), 16'h1);
    chk("n_vec1", 16'(vec_b), 16'h088);
    ack_pulse_b();
    rd_b("n_isr6", 2'd3, 8'h06);
    wr_b(2'd2, 8'h00);
    rd_b("n_eoi1", 2'd3, 8'h04);
    chk("n_still_blk", 16'(rq_b), 16'h0);
    wr_b(2'd2, 8'h00);
    rd_b("n_eoi2", 2'd3, 8'h00);
    chk("n_eoi_edge", 16'(rq_b), 16'h0);
    tick();
    chk("n_rq3", 16'(rq_b), 16'h1);
    chk("n_vec3", 16'(vec_b), 16'h098);
    ack_pulse_b();
    rd_b("n_isr8", 2'd3, 8'h08);

    // level mode on channel 4 with moved base
    wr_a(2'd1, 8'hEF);
    wr_a(2'd3, 8'h20);
    rd_a("lvl_mode", 2'd1, 8'hEF);
    irq_in_a = 8'h10; tick();
    chk("lvl_vec", 16'(vec_a), 16'h060);
    ack_pulse_a();
    chk("lvl_gap", 16'(rq_a), 16'h0);
    tick();
    chk("lvl_again", 16'(rq_a), 16'h1);
    chk("lvl_vec2", 16'(vec_a), 16'h060);
    irq_in_a = 8'h00;
    ack_pulse_a();
    tick();
    chk("lvl_drop", 16'(rq_a), 16'h0);
    ce = 1'b0;
    irq_in_a = 8'h10; tick();
    chk("noce_rq", 16'(rq_a), 16'h0);
    irq_in_a = 8'h00; tick();
    ce = 1'b1; tick();
    chk("lvl_gone", 16'(rq_a), 16'h0);

    // async reset mid-request, source held high through release
    irq_in_a = 8'h01; tick();
    chk("pre_rst_vec", 16'(vec_a), 16'h040);
    reset_n = 1'b0;
    #1;
    chk("async_rst", 16'(rq_a), 16'h0);
    #2;
    reset_n = 1'b1;
    tick();
    chk("post_rst_rq", 16'(rq_a), 16'h1);
    chk("post_rst_vec", 16'(vec_a), 16'h080);
    rd_a("post_rst_mode", 2'd1, 8'hFF);
    irq_in_a = 8'h00;
    ack_pulse_a();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
